curve_pixel_stepper: RTL and testbench
======================================

Name: curve_pixel_stepper

Overview:
- Downstream neighbour of the cubic Bézier point generator; consumes successive sampled curve points over a valid/ready handshake.
- Joins each new point to the previous one with a Bresenham line step, so the drawn curve has no gaps.
- Emits one framebuffer pixel write per cycle (x, y, linear address, colour) under output backpressure.
- Clips off-screen pixels.

Parameters:
- X_WIDTH, 10, coordinate width for x.
- Y_WIDTH, 9, coordinate width for y.
- DISPLAY_WIDTH, 640, visible columns; also the address row stride.
- DISPLAY_HEIGHT, 400, visible rows.
- ADDR_WIDTH, 18, pixel address width.
- COLOR_WIDTH, 4, colour index width.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, reset, asynchronous and active-low.
- point_valid, input, 1, a new curve point is presented.
- point_ready, output, 1, block accepts a point this cycle.
- point_x, input, X_WIDTH, point column.
- point_y, input, Y_WIDTH, point row.
- point_first, input, 1, point starts a new curve; no segment is drawn to it.
- point_color, input, COLOR_WIDTH, colour for the segment ending at this point.
- pixel_valid, output, 1, pixel write is presented.
- pixel_ready, input, 1, downstream accepts the pixel.
- pixel_x, output, X_WIDTH, pixel column.
- pixel_y, output, Y_WIDTH, pixel row.
- pixel_address, output, ADDR_WIDTH, pixel_y*DISPLAY_WIDTH + pixel_x.
- pixel_color, output, COLOR_WIDTH, latched point_color.
- busy, output, 1, high in any state other than IDLE.

Behaviour:
- Reset state, asserted asynchronously:
  - State is IDLE; prev_valid=0.
  - pixel_valid, pixel_x, pixel_y, pixel_address, pixel_color and busy are all 0.
  - point_ready is 1 once reset is released.
- Reset asserted mid-segment: the segment is abandoned immediately, with no further pixels. The next accepted point is treated as first.

- IDLE:
  - point_ready=1.
  - On point_valid&point_ready, latch the point and colour, then go to SETUP.
- SETUP (one cycle):
  - If point_first=1 or prev_valid=0: the cursor is the point itself and no stepping occurs; emit that single pixel (EMIT_LAST).
  - Else if the point equals prev: no pixel; update colour, go to IDLE.
  - Else compute:
    - dx=|x1-x0|, dy=-|y1-y0|;
    - sx, sy = ±1;
    - err=dx+dy, signed X_WIDTH+3 bits;
    - the cursor starts at prev.
    - Go to STEP.
- STEP, combinational advance:
  - e2=2*err.
  - If e2>=dy: err+=dy, x+=sx.
  - If e2<=dx: err+=dx, y+=sy; both updates use the same e2.
  - The advanced cursor is registered as a candidate pixel.
  - The starting pixel (prev) is never re-emitted; the endpoint is always emitted.
- Output register:
  - A candidate inside the display (x<DISPLAY_WIDTH and y<DISPLAY_HEIGHT) drives pixel_valid=1.
  - While pixel_valid&!pixel_ready, all pixel_* outputs and the internal stepper hold.
  - A clipped candidate produces no pixel_valid and costs one cycle.
- Segment end:
  - When the handshaked or clipped pixel equals the endpoint: prev is set to the endpoint, prev_valid=1, go to IDLE.
  - point_ready rises the cycle after the final pixel handshake.
- Latency:
  - Point accepted in cycle N gives the first pixel_valid in cycle N+2.
  - With pixel_ready held high, throughput is 1 pixel per cycle.
- Arithmetic:
  - Coordinates are unsigned; differences are computed sign-extended, so there is no wrap.
  - pixel_address is computed from the registered output x/y with a constant-multiply (shift-add for 640), then registered with the pixel.
- point_first with no prior point is legal and behaves as first.
- A point presented while busy is not accepted; point_ready=0, and the upstream holds the point.

Test Plan:
1. First point (5,7), colour 3, point_first=1, pixel_ready=1 -> exactly one pixel (5,7), address 4485, colour 3, at cycle N+2; point_ready high at N+3.
2. Follow-up point (3,0) after first point (0,0) -> pixels (1,0),(2,0),(3,0), addresses 1,2,3, on consecutive cycles; pixel (0,0) is not repeated.
3. Segment (0,0)->(4,2) -> pixels exactly (1,1),(2,1),(3,2),(4,2) in that order.
4. Same segment with pixel_ready=0 for 3 cycles while (2,1) is presented -> pixel_valid stays 1 and (2,1)/address 642 is stable; then (3,2) follows; no pixel is lost or duplicated.
5. Duplicate point (4,2) after (4,2) -> zero pixels; point_ready returns 1 two cycles after acceptance. Then first (639,399) and next (642,399) -> pixels (640..642,399) are suppressed (no pixel_valid); segment completes in 3 step cycles and prev becomes (642,399).
6. reset_n pulsed low mid-segment -> outputs zero asynchronously. After release, point (10,10) with point_first=0 is drawn as a single pixel (prev_valid cleared).

Source files
------------

// File: rtl/curve_pixel_stepper.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// curve_pixel_stepper
//
// Sits behind the cubic Bezier point generator. Each accepted curve point is
// joined to the previously accepted point with a Bresenham line walk, so the
// rendered curve has no gaps. One framebuffer pixel write (x, y, linear
// address, colour) is presented per cycle under valid/ready backpressure.
// Pixels outside the visible display are clipped: they still cost one step
// cycle but never raise pixel_valid.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   point_valid    upstream presents a curve point
//   point_ready    point is accepted this cycle (high only while idle)
//   point_x/_y     point coordinates (unsigned)
//   point_first    point starts a new curve; it is drawn alone, no segment
//   point_color    colour of the segment ending at this point
//   pixel_valid    pixel write presented
//   pixel_ready    downstream accepts the pixel
//   pixel_x/_y     pixel coordinates
//   pixel_address  pixel_y*DISPLAY_WIDTH + pixel_x
//   pixel_color    colour latched with the point
//   busy           block is not idle
// -----------------------------------------------------------------------------
module curve_pixel_stepper #(
   parameter int X_WIDTH        = 10,
   parameter int Y_WIDTH        = 9,
   parameter int DISPLAY_WIDTH  = 640,
   parameter int DISPLAY_HEIGHT = 400,
   parameter int ADDR_WIDTH     = 18,
   parameter int COLOR_WIDTH    = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   point_valid,
   output logic                   point_ready,
   input  logic [X_WIDTH-1:0]     point_x,
   input  logic [Y_WIDTH-1:0]     point_y,
   input  logic                   point_first,
   input  logic [COLOR_WIDTH-1:0] point_color,
   output logic                   pixel_valid,
   input  logic                   pixel_ready,
   output logic [X_WIDTH-1:0]     pixel_x,
   output logic [Y_WIDTH-1:0]     pixel_y,
   output logic [ADDR_WIDTH-1:0]  pixel_address,
   output logic [COLOR_WIDTH-1:0] pixel_color,
   output logic                   busy
);

   // Error term width: holds dx + dy and every intermediate err value.
   localparam int EW = X_WIDTH + 3;

   localparam logic [1:0] S_IDLE      = 2'd0;
   localparam logic [1:0] S_SETUP     = 2'd1;
   localparam logic [1:0] S_STEP      = 2'd2;
   localparam logic [1:0] S_EMIT_LAST = 2'd3;

   localparam logic [X_WIDTH-1:0]    X_ONE  = 1;
   localparam logic [Y_WIDTH-1:0]    Y_ONE  = 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(DISPLAY_WIDTH);

   function automatic logic in_view(input logic [X_WIDTH-1:0] x,
                                    input logic [Y_WIDTH-1:0] y);
      return (32'(x) < DISPLAY_WIDTH) && (32'(y) < DISPLAY_HEIGHT);
   endfunction

   // Constant multiply by the row stride; for 640 this reduces to
   // (y << 9) + (y << 7) in synthesis.
   function automatic logic [ADDR_WIDTH-1:0] pix_addr(input logic [X_WIDTH-1:0] x,
                                                      input logic [Y_WIDTH-1:0] y);
      return ADDR_WIDTH'(y) * STRIDE + ADDR_WIDTH'(x);
   endfunction

   function automatic logic signed [EW-1:0] abs_s(input logic signed [EW-1:0] v);
      return (v < 0) ? -v : v;
   endfunction

   // One Bresenham advance; both axis decisions use the same e2.
   function automatic void bres_step(
      input  logic [X_WIDTH-1:0]  x,
      input  logic [Y_WIDTH-1:0]  y,
      input  logic signed [EW-1:0] e,
      input  logic signed [EW-1:0] dx,
      input  logic signed [EW-1:0] dy,
      input  logic                 x_neg,
      input  logic                 y_neg,
      output logic [X_WIDTH-1:0]  nx,
      output logic [Y_WIDTH-1:0]  ny,
      output logic signed [EW-1:0] ne);
      logic signed [EW:0]   e2;
      logic signed [EW-1:0] acc;
      e2  = {e[EW-1], e} <<< 1;
      acc = e;
      nx  = x;
      ny  = y;
      if (e2 >= dy) begin
         acc = acc + dy;
         nx  = x_neg ? x - X_ONE : x + X_ONE;
      end
      if (e2 <= dx) begin
         acc = acc + dx;
         ny  = y_neg ? y - Y_ONE : y + Y_ONE;
      end
      ne = acc;
   endfunction

   logic [1:0]             state;
   logic                   prev_valid;
   logic                   cand_vld_p1;   // output stage holds a candidate (visible or clipped)

   logic [X_WIDTH-1:0]     pt_x, prev_x;
   logic [Y_WIDTH-1:0]     pt_y, prev_y;
   logic                   pt_first;
   logic [COLOR_WIDTH-1:0] pt_color;
   logic signed [EW-1:0]   dx_p1, dy_p1, err_p1;
   logic                   xneg_p1, yneg_p1;

   logic signed [EW-1:0]   ddx, ddy, su_dx, su_dy, su_err;
   logic                   su_xneg, su_yneg;
   logic [X_WIDTH-1:0]     in_x, stp_x, cand_x;
   logic [Y_WIDTH-1:0]     in_y, stp_y, cand_y;
   logic signed [EW-1:0]   in_e, in_dx, in_dy, stp_err;
   logic                   in_xneg, in_yneg;
   logic                   accept, is_first, is_dup, consumed, at_end;
   logic                   seg_done, setup_first, setup_line, advance, load_cand;

   assign point_ready = (state == S_IDLE);
   assign busy        = (state != S_IDLE);

   always_comb begin
      // Differences are taken on zero-extended coordinates, so no wrap.
      ddx     = signed'(EW'(pt_x)) - signed'(EW'(prev_x));
      ddy     = signed'(EW'(pt_y)) - signed'(EW'(prev_y));
      su_dx   = abs_s(ddx);
      su_dy   = -abs_s(ddy);
      su_xneg = ddx < 0;
      su_yneg = ddy < 0;
      su_err  = su_dx + su_dy;

      // In SETUP the first step is taken from prev with fresh deltas, which
      // lets the first pixel appear two cycles after acceptance.
      if (state == S_SETUP) begin
         in_x = prev_x;  in_y = prev_y;  in_e = su_err;
         in_dx = su_dx;  in_dy = su_dy;  in_xneg = su_xneg;  in_yneg = su_yneg;
      end else begin
         in_x = pixel_x; in_y = pixel_y; in_e = err_p1;
         in_dx = dx_p1;  in_dy = dy_p1;  in_xneg = xneg_p1;  in_yneg = yneg_p1;
      end
      bres_step(in_x, in_y, in_e, in_dx, in_dy, in_xneg, in_yneg, stp_x, stp_y, stp_err);

      accept      = (state == S_IDLE) && point_valid;
      is_first    = pt_first || !prev_valid;
      is_dup      = (pt_x == prev_x) && (pt_y == prev_y);
      consumed    = cand_vld_p1 && (!pixel_valid || pixel_ready);
      at_end      = (pixel_x == pt_x) && (pixel_y == pt_y);
      seg_done    = ((state == S_STEP) || (state == S_EMIT_LAST)) && consumed && at_end;
      setup_first = (state == S_SETUP) && is_first;
      setup_line  = (state == S_SETUP) && !is_first && !is_dup;
      advance     = (state == S_STEP) && consumed && !at_end;
      load_cand   = setup_first || setup_line || advance;
      cand_x      = setup_first ? pt_x : stp_x;
      cand_y      = setup_first ? pt_y : stp_y;
   end

   // Control and output stage
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         prev_valid    <= 1'b0;
         cand_vld_p1   <= 1'b0;
         pixel_valid   <= 1'b0;
         pixel_x       <= '0;
         pixel_y       <= '0;
         pixel_address <= '0;
         pixel_color   <= '0;
      end else begin
         case (state)
            S_IDLE:  if (accept) state <= S_SETUP;
            S_SETUP: begin
               if (is_first)    state <= S_EMIT_LAST;
               else if (is_dup) state <= S_IDLE;
               else             state <= S_STEP;
            end
            default: if (seg_done) begin
               state      <= S_IDLE;
               prev_valid <= 1'b1;
            end
         endcase

         if (load_cand) begin
            cand_vld_p1   <= 1'b1;
            pixel_valid   <= in_view(cand_x, cand_y);
            pixel_x       <= cand_x;
            pixel_y       <= cand_y;
            pixel_address <= pix_addr(cand_x, cand_y);
            pixel_color   <= pt_color;
         end else if (seg_done) begin
            cand_vld_p1 <= 1'b0;
            pixel_valid <= 1'b0;
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (accept) begin
         pt_x     <= point_x;
         pt_y     <= point_y;
         pt_first <= point_first;
         pt_color <= point_color;
      end
      if (setup_line) begin
         dx_p1   <= su_dx;
         dy_p1   <= su_dy;
         xneg_p1 <= su_xneg;
         yneg_p1 <= su_yneg;
      end
      if (setup_line || advance) err_p1 <= stp_err;
      if (seg_done) begin
         prev_x <= pt_x;
         prev_y <= pt_y;
      end
   end

endmodule

// File: tb/tb_curve_pixel_stepper.sv
`timescale 1ns/1ps
module tb_curve_pixel_stepper;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        point_valid;
   logic        point_ready;
   logic [9:0]  point_x;
   logic [8:0]  point_y;
   logic        point_first;
   logic [3:0]  point_color;
   logic        pixel_valid;
   logic        pixel_ready;
   logic [9:0]  pixel_x;
   logic [8:0]  pixel_y;
   logic [17:0] pixel_address;
   logic [3:0]  pixel_color;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   curve_pixel_stepper dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .point_valid   (point_valid),
      .point_ready   (point_ready),
      .point_x       (point_x),
      .point_y       (point_y),
      .point_first   (point_first),
      .point_color   (point_color),
      .pixel_valid   (pixel_valid),
      .pixel_ready   (pixel_ready),
      .pixel_x       (pixel_x),
      .pixel_y       (pixel_y),
      .pixel_address (pixel_address),
      .pixel_color   (pixel_color),
      .busy          (busy)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_pix(input string tag, input int x, input int y, input int addr, input int col);
      chk({tag, "_valid"}, 32'(pixel_valid), 1);
      chk({tag, "_x"}, 32'(pixel_x), x);
      chk({tag, "_y"}, 32'(pixel_y), y);
      chk({tag, "_addr"}, 32'(pixel_address), addr);
      chk({tag, "_color"}, 32'(pixel_color), col);
   endtask

   task automatic chk_none(input string tag);
      chk({tag, "_valid"}, 32'(pixel_valid), 0);
   endtask

   // Presents a point and returns at the cycle after it was accepted.
   task automatic send(input int x, input int y, input logic first, input int col);
      int n;
      point_x     = 10'(x);
      point_y     = 9'(y);
      point_first = first;
      point_color = 4'(col);
      point_valid = 1'b1;
      n = 0;
      while (!point_ready && n < 50) begin
         tick;
         n++;
      end
      chk("send_ready", 32'(point_ready), 1);
      tick;
      point_valid = 1'b0;
   endtask

   task automatic drain;
      int n;
      n = 0;
      while (busy && n < 50) begin
         tick;
         n++;
      end
      chk("drain_idle", 32'(busy), 0);
   endtask

   initial begin
      reset_n     = 1'b0;
      point_valid = 1'b0;
      point_x     = '0;
      point_y     = '0;
      point_first = 1'b0;
      point_color = '0;
      pixel_ready = 1'b1;

      #2;
      chk("rst_pixel_valid", 32'(pixel_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_x", 32'(pixel_x), 0);
      chk("rst_y", 32'(pixel_y), 0);
      chk("rst_addr", 32'(pixel_address), 0);
      chk("rst_color", 32'(pixel_color), 0);
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      tick;
      chk("rst_point_ready", 32'(point_ready), 1);

      // First point alone: pixel at N+2, ready again at N+3
      send(5, 7, 1'b1, 3);
      chk("t1_setup_busy", 32'(busy), 1);
      chk_none("t1_setup");
      tick;
      chk_pix("t1_pix", 5, 7, 4485, 3);
      chk("t1_ready_low", 32'(point_ready), 0);
      tick;
      chk_none("t1_after");
      chk("t1_ready_back", 32'(point_ready), 1);

      // Horizontal segment (0,0)->(3,0)
      send(0, 0, 1'b1, 1);
      drain;
      send(3, 0, 1'b0, 2);
      chk_none("t2_setup");
      tick; chk_pix("t2_p1", 1, 0, 1, 2);
      tick; chk_pix("t2_p2", 2, 0, 2, 2);
      tick; chk_pix("t2_p3", 3, 0, 3, 2);
      tick;
      chk_none("t2_end");
      chk("t2_ready", 32'(point_ready), 1);

      // Diagonal segment (0,0)->(4,2)
      send(0, 0, 1'b1, 5);
      drain;
      send(4, 2, 1'b0, 5);
      tick; chk_pix("t3_p1", 1, 1, 641, 5);
      tick; chk_pix("t3_p2", 2, 1, 642, 5);
      tick; chk_pix("t3_p3", 3, 2, 1283, 5);
      tick; chk_pix("t3_p4", 4, 2, 1284, 5);
      tick; chk_none("t3_end");

      // Same segment with a 3-cycle stall on (2,1)
      send(0, 0, 1'b1, 6);
      drain;
      send(4, 2, 1'b0, 6);
      tick; chk_pix("t4_p1", 1, 1, 641, 6);
      tick; chk_pix("t4_p2", 2, 1, 642, 6);
      pixel_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_pix("t4_stall", 2, 1, 642, 6);
      end
      pixel_ready = 1'b1;
      tick; chk_pix("t4_p3", 3, 2, 1283, 6);
      tick; chk_pix("t4_p4", 4, 2, 1284, 6);
      tick;
      chk_none("t4_end");
      chk("t4_ready", 32'(point_ready), 1);

      // Duplicate point: no pixel, ready two cycles after acceptance
      send(4, 2, 1'b0, 7);
      chk_none("t5_dup_setup");
      chk("t5_dup_ready_low", 32'(point_ready), 0);
      tick;
      chk_none("t5_dup_after");
      chk("t5_dup_ready", 32'(point_ready), 1);

      // Bottom-right corner, then a fully clipped segment
      send(639, 399, 1'b1, 8);
      tick; chk_pix("t5_corner", 639, 399, 255999, 8);
      tick; chk_none("t5_corner_end");
      send(642, 399, 1'b0, 9);
      chk_none("t5_clip_setup");
      for (int i = 0; i < 3; i++) begin
         tick;
         chk_none("t5_clip");
         chk("t5_clip_busy", 32'(busy), 1);
      end
      tick;
      chk("t5_clip_done", 32'(busy), 0);
      chk("t5_clip_ready", 32'(point_ready), 1);

      // Walk back from prev (642,399): two clipped steps, then (639,399)
      send(639, 399, 1'b0, 10);
      tick; chk_none("t5_back_641");
      tick; chk_none("t5_back_640");
      tick; chk_pix("t5_back_639", 639, 399, 255999, 10);
      tick; chk_none("t5_back_end");

      // Reset mid-segment
      send(0, 0, 1'b1, 4);
      drain;
      send(3, 0, 1'b0, 4);
      tick; chk_pix("t6_p1", 1, 0, 1, 4);
      #2 reset_n = 1'b0;
      #1;
      chk_none("t6_rst");
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_x", 32'(pixel_x), 0);
      chk("t6_rst_addr", 32'(pixel_address), 0);
      chk("t6_rst_color", 32'(pixel_color), 0);
      @(negedge clk);
      reset_n = 1'b1;
      tick;
      chk("t6_ready", 32'(point_ready), 1);
      send(10, 10, 1'b0, 12);
      tick; chk_pix("t6_single", 10, 10, 6410, 12);
      tick;
      chk_none("t6_end");
      chk("t6_idle", 32'(busy), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
